// File: rtl/wb_regfile_stage_pkg.sv
// Shared widths, PC index and write-back source encoding for the WB stage.
package wb_regfile_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 15;
    localparam int unsigned CNT_W      = 32;

    localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'd15;

    // MEM_R_en meaning: 1 selects load data, 0 selects the ALU result.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_regfile_stage_regfile.sv
// R0..R14 storage: one synchronous write port, two asynchronous read ports, synchronous clear.
module regfile_15x32
    import wb_regfile_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != PC_IDX)) begin
            mem[waddr] <= wdata;
        end
    end

    // Index 15 has no storage behind it and reads as zero.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != PC_IDX) rdata1 = mem[raddr1];
        if (raddr2 != PC_IDX) rdata2 = mem[raddr2];
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the WB value, commits it to R0..R14, bypasses it to the ID read ports.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_en,
    input  logic                  MEM_R_en,
    input  logic [DATA_W-1:0]     ALU_result,
    input  logic [DATA_W-1:0]     MEM_read_value,
    input  logic [REG_ADDR_W-1:0] Dest,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic [DATA_W-1:0]     reg1,
    output logic [DATA_W-1:0]     reg2,
    output logic [DATA_W-1:0]     WB_value,
    output logic [CNT_W-1:0]      wb_count,
    output logic                  pc_write_err
);

    logic              commit;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    assign WB_value = (wb_src_e'(MEM_R_en) == WB_SRC_MEM) ? MEM_read_value : ALU_result;
    assign commit   = WB_en && (Dest != PC_IDX);

    regfile_15x32 u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (commit),
        .waddr  (Dest),
        .wdata  (WB_value),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (rf_data1),
        .rdata2 (rf_data2)
    );

    // Same-cycle bypass replaces a half-cycle register-file write.
    always_comb begin
        reg1 = rf_data1;
        reg2 = rf_data2;
        if (src1 == PC_IDX)                 reg1 = '0;
        else if (commit && (Dest == src1))  reg1 = WB_value;
        if (src2 == PC_IDX)                 reg2 = '0;
        else if (commit && (Dest == src2))  reg2 = WB_value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (commit)                         cnt_q <= cnt_q + CNT_W'(1);
            if (WB_en && (Dest == PC_IDX))      err_q <= 1'b1;
        end
    end

    assign wb_count     = cnt_q;
    assign pc_write_err = err_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed vector table, wrap backdoor, random scoreboard run.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en;
    logic        MEM_R_en;
    logic [31:0] ALU_result;
    logic [31:0] MEM_read_value;
    logic [3:0]  Dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] WB_value;
    logic [31:0] wb_count;
    logic        pc_write_err;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk            (clk),
        .rst            (rst),
        .WB_en          (WB_en),
        .MEM_R_en       (MEM_R_en),
        .ALU_result     (ALU_result),
        .MEM_read_value (MEM_read_value),
        .Dest           (Dest),
        .src1           (src1),
        .src2           (src2),
        .reg1           (reg1),
        .reg2           (reg2),
        .WB_value       (WB_value),
        .wb_count       (wb_count),
        .pc_write_err   (pc_write_err)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
    } vin_t;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] wbv;
        logic [31:0] cnt;
        logic        err;
    } vexp_t;

    typedef struct {
        vin_t  i;
        vexp_t e;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    vexp_t sb_q[$];

    logic [31:0] m_r [15];
    logic [31:0] m_cnt;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive just after a rising edge, compare at the falling edge, then return just after the next rising edge.
    task automatic apply(input vin_t v, input vexp_t e, input string tag);
        vexp_t x;
        rst = v.rst; WB_en = v.we; MEM_R_en = v.mr; ALU_result = v.alu;
        MEM_read_value = v.mem; Dest = v.dest; src1 = v.s1; src2 = v.s2;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            check({tag, ".reg1"}, reg1, x.r1);
            check({tag, ".reg2"}, reg2, x.r2);
            check({tag, ".WB_value"}, WB_value, x.wbv);
            check({tag, ".wb_count"}, wb_count, x.cnt);
            check({tag, ".pc_write_err"}, 32'(pc_write_err), 32'(x.err));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vin_t mk(input logic r, input logic we, input logic mr, input logic [31:0] alu,
                                input logic [31:0] mem, input logic [3:0] d, input logic [3:0] a,
                                input logic [3:0] b);
        vin_t v;
        v.rst = r; v.we = we; v.mr = mr; v.alu = alu; v.mem = mem; v.dest = d; v.s1 = a; v.s2 = b;
        return v;
    endfunction

    function automatic vexp_t ex(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] wbv,
                                 input logic [31:0] cnt, input logic err);
        vexp_t e;
        e.r1 = r1; e.r2 = r2; e.wbv = wbv; e.cnt = cnt; e.err = err;
        return e;
    endfunction

    // Reference read port: PC reads zero, a committing write to the same index wins, else stored value.
    function automatic logic [31:0] m_read(input vin_t v, input logic [3:0] s);
        logic [31:0] wbv;
        wbv = v.mr ? v.mem : v.alu;
        if (s == 4'd15) return 32'h0;
        if (v.we && v.dest == s) return wbv;
        return m_r[s];
    endfunction

    vec_t tbl [11];

    initial begin
        vin_t  v;
        vexp_t e;

        tbl[0]  = '{mk(0,1,0,32'h1234,32'h0,5,5,0),           ex(32'h1234,32'h0,32'h1234,0,0)};
        tbl[1]  = '{mk(0,0,0,32'h0,32'h0,0,5,5),              ex(32'h1234,32'h1234,32'h0,1,0)};
        tbl[2]  = '{mk(0,1,1,32'h7,32'hCAFE_0001,14,14,14),   ex(32'hCAFE_0001,32'hCAFE_0001,32'hCAFE_0001,1,0)};
        tbl[3]  = '{mk(0,0,0,32'h0,32'h0,0,14,14),            ex(32'hCAFE_0001,32'hCAFE_0001,32'h0,2,0)};
        tbl[4]  = '{mk(0,1,0,32'h99,32'h0,15,15,5),           ex(32'h0,32'h1234,32'h99,2,0)};
        tbl[5]  = '{mk(0,0,0,32'h0,32'h0,0,15,14),            ex(32'h0,32'hCAFE_0001,32'h0,2,1)};
        tbl[6]  = '{mk(0,1,0,32'h77,32'h0,2,2,3),             ex(32'h77,32'h0,32'h77,2,1)};
        tbl[7]  = '{mk(0,0,0,32'h55,32'h0,2,0,2),             ex(32'h0,32'h77,32'h55,3,1)};
        tbl[8]  = '{mk(0,0,1,32'h0,32'h66,2,3,2),             ex(32'h0,32'h77,32'h66,3,1)};
        tbl[9]  = '{mk(0,1,0,32'hAAAA,32'h0,0,0,0),           ex(32'hAAAA,32'hAAAA,32'hAAAA,3,1)};
        tbl[10] = '{mk(0,0,0,32'h0,32'h0,0,0,1),              ex(32'hAAAA,32'h0,32'h0,4,1)};

        // Reset cycles with a pending write that must be discarded.
        rst = 1; WB_en = 1; MEM_R_en = 0; ALU_result = 32'hDEAD_BEEF; MEM_read_value = 0;
        Dest = 3; src1 = 3; src2 = 0;
        repeat (2) @(posedge clk);
        #1;
        apply(mk(0,0,0,32'h0,32'h0,0,3,4), ex(0,0,0,0,0), "reset");

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));
        end

        // PC-write error stays sticky over idle cycles; count frozen.
        for (int i = 0; i < 10; i++) begin
            apply(mk(0,0,0,32'h0,32'h0,15,15,14), ex(0,32'hCAFE_0001,0,4,1), $sformatf("idle%0d", i));
        end

        // Counter wrap via backdoor preload.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        apply(mk(0,1,0,32'h1111,32'h0,1,1,2), ex(32'h1111,32'h77,32'h1111,32'hFFFF_FFFF,1), "wrap_commit");
        apply(mk(0,0,0,32'h0,32'h0,0,1,2), ex(32'h1111,32'h77,32'h0,32'h0,1), "wrap_after");

        // Reset again, then random traffic against the reference model.
        apply(mk(1,1,0,32'h5,32'h0,4,0,0), ex(32'hAAAA,32'hAAAA,32'h5,0,1), "rst2_cycle");
        for (int i = 0; i < 15; i++) m_r[i] = 32'h0;
        m_cnt = 0;
        m_err = 0;

        for (int n = 0; n < 300; n++) begin
            v.rst  = 1'b0;
            v.we   = 1'($urandom_range(0, 1));
            v.mr   = 1'($urandom_range(0, 1));
            v.alu  = $urandom;
            v.mem  = $urandom;
            v.dest = 4'($urandom_range(0, 15));
            v.s1   = ($urandom_range(0, 3) == 0) ? v.dest : 4'($urandom_range(0, 15));
            v.s2   = ($urandom_range(0, 3) == 0) ? v.s1   : 4'($urandom_range(0, 15));
            e.r1  = m_read(v, v.s1);
            e.r2  = m_read(v, v.s2);
            e.wbv = v.mr ? v.mem : v.alu;
            e.cnt = m_cnt;
            e.err = m_err;
            apply(v, e, $sformatf("rnd%0d", n));
            if (v.we && v.dest != 4'd15) begin
                m_r[v.dest] = e.wbv;
                m_cnt = m_cnt + 32'd1;
            end
            if (v.we && v.dest == 4'd15) m_err = 1'b1;
        end

        if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
